ex: RTL and testbench

Execute stage of the five-stage RV32IM core, consuming the instruction, operands, destination and write-enable registered by the ID/EX pipeline register. It computes integer ALU results, resolves branches and jumps, and produces the register-file write port plus jump and hold requests to the pipeline controller. DIV/DIVU/REM/REMU run on an iterative radix-2 divider. EX requests a pipeline hold until the quotient or remainder is ready.

---
 rtl/ex_pkg.sv | 52 +++++
 rtl/div_iter.sv | 92 +++++++++
 rtl/ex.sv | 177 +++++++++++++++++
 tb/tb_ex.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared RV32IM encodings and divider state types for the execute stage.
// Imported by ex and div_iter.
package ex_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_M = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

  function automatic logic [31:0] mag(
    input logic [31:0] v,
    input logic        s
  );
    return (s && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, one step per cycle.
// start is a 1-cycle pulse; ready is high for the single DONE cycle.
module div_iter
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic [1:0]  op,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        ready,
  output logic [31:0] result,
  output logic [4:0]  rd
);

  div_state_t  state, state_d;
  logic [5:0]  cnt;
  logic [31:0] a_q, b_q;
  logic [31:0] quo, rem, dvs;
  logic [1:0]  op_q;
  logic [4:0]  rd_q;
  logic [32:0] trial;
  logic        sgn, q_neg, r_neg;

  always_comb begin
    state_d = state;
    unique case (state)
      DIV_IDLE:
        if (start)
          state_d = (divisor == '0) ? DIV_DONE : DIV_BUSY;
      DIV_BUSY:
        if (cnt == 6'd31) state_d = DIV_DONE;
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= (state == DIV_BUSY) ? cnt + 6'd1 : '0;
    end
  end

  // op[0] = unsigned, op[1] = remainder
  assign trial = {rem, quo[31]} - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (state == DIV_IDLE && start) begin
      a_q  <= dividend;
      b_q  <= divisor;
      op_q <= op;
      rd_q <= rd_in;
      quo  <= mag(dividend, ~op[0]);
      dvs  <= mag(divisor, ~op[0]);
      rem  <= '0;
    end else if (state == DIV_BUSY) begin
      if (!trial[32]) begin
        rem <= trial[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= {rem[30:0], quo[31]};
        quo <= {quo[30:0], 1'b0};
      end
    end
  end

  assign sgn   = ~op_q[0];
  assign q_neg = sgn & (a_q[31] ^ b_q[31]);
  assign r_neg = sgn & a_q[31];

  always_comb begin
    result = '0;
    if (b_q == '0)
      result = op_q[1] ? a_q : '1;
    else if (op_q[1])
      result = r_neg ? -rem : rem;
    else
      result = q_neg ? -quo : quo;
  end

  assign busy  = (state == DIV_BUSY);
  assign ready = (state == DIV_DONE);
  assign rd    = rd_q;

endmodule

// File: rtl/ex.sv
// RV32IM execute stage: ALU, multiplier, branch unit and
// write-back mux over the iterative divider.
module ex
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            reg_wen_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wen_o,
  output logic            jump_en_o,
  output logic [XLEN-1:0] jump_addr_o,
  output logic            hold_o
);

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic        is_m, is_div, is_mul, is_alu;
  logic [31:0] imm_i, imm_b, imm_j;
  logic [31:0] alu_res, mul_res, pc4;
  logic [63:0] ma, mb, prod;
  logic        br_take;
  logic [31:0] res, jaddr;
  logic        wen, jmp;
  logic        div_start, div_busy, div_ready;
  logic [31:0] div_res;
  logic [4:0]  div_rd;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];
  assign is_m   = (opcode == OPC_OP) && (f7 == F7_M);
  assign is_div = is_m & f3[2];
  assign is_mul = is_m & ~f3[2];
  assign is_alu = (opcode == OPC_OP_IMM) ||
                  ((opcode == OPC_OP) && !is_m);

  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                  inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                  inst_i[20], inst_i[30:21], 1'b0};
  assign pc4   = inst_addr_i + 32'd4;

  always_comb begin
    alu_res = '0;
    case (f3)
      F3_ADD:
        alu_res = ((opcode == OPC_OP) && inst_i[30])
                  ? op1_i - op2_i : op1_i + op2_i;
      F3_SLL:  alu_res = op1_i << op2_i[4:0];
      F3_SLT:  alu_res = {31'b0, $signed(op1_i) < $signed(op2_i)};
      F3_SLTU: alu_res = {31'b0, op1_i < op2_i};
      F3_XOR:  alu_res = op1_i ^ op2_i;
      F3_SR:
        alu_res = inst_i[30]
                  ? 32'($signed(op1_i) >>> op2_i[4:0])
                  : op1_i >> op2_i[4:0];
      F3_OR:   alu_res = op1_i | op2_i;
      F3_AND:  alu_res = op1_i & op2_i;
      default: alu_res = '0;
    endcase
  end

  // one 64x64 multiplier; sign-extension picks the flavour
  assign ma = (f3 == F3_MULH || f3 == F3_MULHSU)
              ? {{32{op1_i[31]}}, op1_i} : {32'b0, op1_i};
  assign mb = (f3 == F3_MULH)
              ? {{32{op2_i[31]}}, op2_i} : {32'b0, op2_i};
  assign prod    = ma * mb;
  assign mul_res = (f3 == F3_MUL) ? prod[31:0] : prod[63:32];

  always_comb begin
    br_take = 1'b0;
    case (f3)
      F3_BEQ:  br_take = op1_i == op2_i;
      F3_BNE:  br_take = op1_i != op2_i;
      F3_BLT:  br_take = $signed(op1_i) < $signed(op2_i);
      F3_BGE:  br_take = $signed(op1_i) >= $signed(op2_i);
      F3_BLTU: br_take = op1_i < op2_i;
      F3_BGEU: br_take = op1_i >= op2_i;
      default: br_take = 1'b0;
    endcase
  end

  always_comb begin
    res   = '0;
    wen   = 1'b0;
    jmp   = 1'b0;
    jaddr = '0;
    unique case (1'b1)
      is_alu: begin
        res = alu_res;
        wen = reg_wen_i;
      end
      is_mul: begin
        res = mul_res;
        wen = reg_wen_i;
      end
      (opcode == OPC_LUI): begin
        res = op2_i;
        wen = reg_wen_i;
      end
      (opcode == OPC_AUIPC): begin
        res = op1_i + op2_i;
        wen = reg_wen_i;
      end
      (opcode == OPC_JAL): begin
        res   = pc4;
        wen   = reg_wen_i;
        jmp   = 1'b1;
        jaddr = inst_addr_i + imm_j;
      end
      (opcode == OPC_JALR): begin
        res   = pc4;
        wen   = reg_wen_i;
        jmp   = 1'b1;
        jaddr = (op1_i + imm_i) & ~32'd1;
      end
      (opcode == OPC_BRANCH): begin
        jmp   = br_take;
        jaddr = inst_addr_i + imm_b;
      end
      default: ;
    endcase
  end

  assign div_start = ~rst & is_div & ~div_busy & ~div_ready;

  div_iter u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (op1_i),
    .divisor  (op2_i),
    .op       (f3[1:0]),
    .rd_in    (rd_addr_i),
    .busy     (div_busy),
    .ready    (div_ready),
    .result   (div_res),
    .rd       (div_rd)
  );

  // DONE wins over a still-present div instruction so it never restarts
  always_comb begin
    rd_addr_o   = '0;
    rd_data_o   = '0;
    rd_wen_o    = 1'b0;
    jump_en_o   = 1'b0;
    jump_addr_o = '0;
    hold_o      = 1'b0;
    if (rst) begin
      hold_o = 1'b0;
    end else if (div_ready) begin
      rd_addr_o = div_rd;
      rd_data_o = div_res;
      rd_wen_o  = 1'b1;
    end else if (div_busy || is_div) begin
      hold_o = 1'b1;
    end else begin
      rd_addr_o   = rd_addr_i;
      rd_data_o   = res;
      rd_wen_o    = wen;
      jump_en_o   = jmp;
      jump_addr_o = jaddr;
    end
  end

endmodule

// File: tb/tb_ex.sv
// Scoreboard bench for the execute stage: per-cycle expectations
// are queued by the stimulus and popped by a negedge monitor.
module tb_ex;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i, inst_addr_i, op1_i, op2_i;
  logic [4:0]  rd_addr_i;
  logic        reg_wen_i;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o, jump_addr_o;
  logic        rd_wen_o, jump_en_o, hold_o;

  always #5 clk = ~clk;

  ex dut (
    .clk         (clk),
    .rst         (rst),
    .inst_i      (inst_i),
    .inst_addr_i (inst_addr_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .rd_addr_i   (rd_addr_i),
    .reg_wen_i   (reg_wen_i),
    .rd_addr_o   (rd_addr_o),
    .rd_data_o   (rd_data_o),
    .rd_wen_o    (rd_wen_o),
    .jump_en_o   (jump_en_o),
    .jump_addr_o (jump_addr_o),
    .hold_o      (hold_o)
  );

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        zero;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        jmp;
    logic [31:0] jaddr;
    logic        hold;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    checks = 0;
  int    passed = 0;

  function automatic exp_t e_none();
    exp_t e;
    e.zero = 0; e.wen = 0; e.rd = 0; e.data = 0;
    e.jmp = 0; e.jaddr = 0; e.hold = 0;
    return e;
  endfunction

  function automatic exp_t e_zero();
    exp_t e = e_none();
    e.zero = 1;
    return e;
  endfunction

  function automatic exp_t e_hold();
    exp_t e = e_none();
    e.hold = 1;
    return e;
  endfunction

  function automatic exp_t e_wr(logic [4:0] rd, logic [31:0] d);
    exp_t e = e_none();
    e.wen = 1; e.rd = rd; e.data = d;
    return e;
  endfunction

  function automatic exp_t e_jmp(logic [31:0] a);
    exp_t e = e_none();
    e.jmp = 1; e.jaddr = a;
    return e;
  endfunction

  function automatic logic [31:0] rt(logic [6:0] f7, logic [2:0] f3,
                                     logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] it(logic [11:0] imm, logic [2:0] f3,
                                     logic [4:0] rd, logic [6:0] op);
    return {imm, 5'd1, f3, rd, op};
  endfunction

  function automatic logic [31:0] bt(logic [12:0] imm, logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] jt(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  always @(negedge clk) begin
    exp_t  e;
    string n;
    logic  ok;
    if (q.size() > 0) begin
      e = q.pop_front();
      n = nq.pop_front();
      checks++;
      if (e.zero)
        ok = !rd_wen_o && !jump_en_o && !hold_o && rd_addr_o == 0 &&
             rd_data_o == 0 && jump_addr_o == 0;
      else
        ok = (hold_o == e.hold) && (jump_en_o == e.jmp) &&
             (!e.jmp || jump_addr_o == e.jaddr) &&
             (rd_wen_o == e.wen) &&
             (!e.wen || (rd_addr_o == e.rd && rd_data_o == e.data));
      if (ok) passed++;
      else
        $display("FAIL %s: got wen=%0b rd=%0d data=%h jmp=%0b addr=%h hold=%0b; want zero=%0b wen=%0b rd=%0d data=%h jmp=%0b addr=%h hold=%0b",
                 n, rd_wen_o, rd_addr_o, rd_data_o, jump_en_o, jump_addr_o,
                 hold_o, e.zero, e.wen, e.rd, e.data, e.jmp, e.jaddr, e.hold);
    end
  end

  task automatic step(input string n, input logic r, input logic [31:0] in,
                      input logic [31:0] pc, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd,
                      input logic w, input exp_t e);
    rst = r; inst_i = in; inst_addr_i = pc;
    op1_i = a; op2_i = b; rd_addr_i = rd; reg_wen_i = w;
    q.push_back(e);
    nq.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic div_run(input string n, input logic [31:0] in,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic dz,
                         input logic [31:0] r);
    step({n, " start"}, 0, in, 32'h300, a, b, rd, 1, e_hold());
    if (!dz)
      for (int i = 0; i < 32; i++)
        step({n, " busy"}, 0, in, 32'h300, a, b, rd, 1, e_hold());
    step({n, " done"}, 0, in, 32'h300, a, b, rd, 1, e_wr(rd, r));
    step({n, " after"}, 0, NOP, 32'h304, 0, 0, 0, 0, e_none());
  endtask

  initial begin
    rst = 1; inst_i = NOP; inst_addr_i = 0;
    op1_i = 0; op2_i = 0; rd_addr_i = 0; reg_wen_i = 0;
    @(posedge clk);
    #1;
    step("reset0", 1, rt(0, 0, 3), 0, 1, 2, 3, 1, e_zero());
    step("reset1", 1, NOP, 0, 0, 0, 0, 0, e_zero());

    step("add ovf", 0, rt(0, 0, 3), 0, 32'h7fff_ffff, 1, 3, 1,
         e_wr(3, 32'h8000_0000));
    step("add x0", 0, rt(0, 0, 0), 0, 4, 5, 0, 1, e_wr(0, 9));
    step("sub", 0, rt(7'h20, 0, 4), 0, 5, 7, 4, 1, e_wr(4, 32'hffff_fffe));
    step("srai", 0, it(12'h404, 5, 6, 7'h13), 0, 32'h8000_0000,
         32'h404, 6, 1, e_wr(6, 32'hf800_0000));
    step("slt", 0, rt(0, 2, 7), 0, 32'hffff_ffff, 0, 7, 1, e_wr(7, 1));
    step("sltu", 0, rt(0, 3, 7), 0, 32'hffff_ffff, 0, 7, 1, e_wr(7, 0));
    step("lui", 0, {20'h12345, 5'd8, 7'h37}, 0, 0, 32'h1234_5000, 8, 1,
         e_wr(8, 32'h1234_5000));
    step("auipc", 0, {20'h00001, 5'd8, 7'h17}, 32'h100, 32'h100,
         32'h1000, 8, 1, e_wr(8, 32'h1100));
    step("mul", 0, rt(1, 0, 9), 0, 7, 6, 9, 1, e_wr(9, 42));
    step("mulh", 0, rt(1, 1, 9), 0, 32'hffff_fffe, 3, 9, 1,
         e_wr(9, 32'hffff_ffff));
    step("mulhsu", 0, rt(1, 2, 9), 0, 32'hffff_ffff, 2, 9, 1,
         e_wr(9, 32'hffff_ffff));
    step("mulhu", 0, rt(1, 3, 9), 0, 32'hffff_ffff, 32'hffff_ffff, 9, 1,
         e_wr(9, 32'hffff_fffe));
    step("blt taken", 0, bt(13'd16, 3'b100), 32'h100, 32'hffff_ffff, 0,
         0, 0, e_jmp(32'h110));
    step("blt not", 0, bt(13'd16, 3'b100), 32'h100, 0, 0, 0, 0, e_none());
    step("beq back", 0, bt(13'h1ff8, 3'b000), 32'h100, 5, 5, 0, 0,
         e_jmp(32'h0f8));
    begin
      exp_t e = e_wr(1, 32'h204);
      e.jmp = 1; e.jaddr = 32'h208;
      step("jal", 0, jt(21'd8, 1), 32'h200, 32'h200, 0, 1, 1, e);
      e.jaddr = 32'h1004;
      step("jalr", 0, it(12'd4, 0, 1, 7'h67), 32'h200, 32'h1001, 4, 1, 1, e);
    end
    step("load", 0, it(12'd0, 2, 5, 7'h03), 0, 32'h40, 0, 5, 1, e_none());

    div_run("div", rt(1, 4, 10), 32'hffff_fff9, 2, 10, 0, 32'hffff_fffd);
    div_run("rem", rt(1, 6, 11), 32'hffff_fff9, 2, 11, 0, 32'hffff_ffff);
    div_run("divu0", rt(1, 5, 12), 5, 0, 12, 1, 32'hffff_ffff);
    div_run("remu0", rt(1, 7, 13), 5, 0, 13, 1, 5);
    div_run("div ovf", rt(1, 4, 14), 32'h8000_0000, 32'hffff_ffff, 14, 0,
            32'h8000_0000);
    step("ovf idle", 0, NOP, 0, 0, 0, 0, 0, e_none());

    step("rdiv start", 0, rt(1, 4, 15), 0, 100, 7, 15, 1, e_hold());
    for (int i = 0; i < 9; i++)
      step("rdiv busy", 0, rt(1, 4, 15), 0, 100, 7, 15, 1, e_hold());
    step("rdiv reset", 1, rt(1, 4, 15), 0, 100, 7, 15, 1, e_zero());
    for (int i = 0; i < 36; i++)
      step("rdiv nowrite", 0, NOP, 0, 0, 0, 0, 0, e_none());
    step("add post", 0, rt(0, 0, 3), 0, 10, 20, 3, 1, e_wr(3, 30));

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
